// File: rtl/buffer_drain_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// buffer_drain_ctrl_pkg
//   Shared definitions for the post-FFT IQ buffer read-side controller:
//   default sample width, buffer/block sizes, FSM state encodings and the
//   fill-threshold clamp helper.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package buffer_drain_ctrl_pkg;

  localparam int FP_DEF    = 10;   // buffer sample field; each rail is FP/2 bits
  localparam int BUF_DEPTH = 144;  // buffer capacity in samples
  localparam int PBCH_BLK  = 144;  // samples delivered per start command

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A fill threshold above the block size could never be satisfied by a
  // block-sized transaction, so it saturates at the block size.
  function automatic logic [7:0] clamp_thr(input logic [7:0] thr,
                                           input logic [7:0] blk);
    return (thr > blk) ? blk : thr;
  endfunction

endpackage

// File: rtl/buffer_drain_ctrl_skid.sv
// ---------------------------------------------------------------------------
// iq_skid2
//   Two-entry FIFO for {i,q} samples sitting between the buffer's registered
//   read port and the output stream. The head entry is a register that
//   drives the stream directly, so the outputs are registered.
//   Ports:
//     clk, rst            clock, async active-low reset
//     clr                 synchronous flush (drops both entries)
//     wr, new_i, new_q    write one sample
//     rd                  remove the head sample (only when cnt != 0)
//     head_i, head_q      current head sample
//     cnt[1:0]            number of stored samples, 0..2
//   The caller guarantees no write into a full FIFO without a same-cycle read.
// ---------------------------------------------------------------------------
module iq_skid2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] new_i,
  input  logic [W-1:0] new_q,
  input  logic         rd,
  output logic [W-1:0] head_i,
  output logic [W-1:0] head_q,
  output logic [1:0]   cnt
);

  logic [W-1:0] tail_i;
  logic [W-1:0] tail_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data registers are reset too, because the head drives the
      // stream outputs, which must read zero while in reset.
      cnt    <= 2'd0;
      head_i <= '0;
      head_q <= '0;
      tail_i <= '0;
      tail_q <= '0;
    end else if (clr) begin
      cnt    <= 2'd0;
      head_i <= '0;
      head_q <= '0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_i <= new_i;
            head_q <= new_q;
          end else begin
            tail_i <= new_i;
            tail_q <= new_q;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_i <= tail_i;
          head_q <= tail_q;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new sample lands behind whatever remains.
          if (cnt == 2'd1) begin
            head_i <= new_i;
            head_q <= new_q;
          end else begin
            head_i <= tail_i;
            head_q <= tail_q;
            tail_i <= new_i;
            tail_q <= new_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/buffer_drain_ctrl.sv
// ---------------------------------------------------------------------------
// buffer_drain_ctrl
//   Read-side controller for the post-FFT IQ buffer. Mirrors buffer occupancy
//   from push/pop, issues pops (never into an empty buffer), absorbs the
//   buffer's 1-cycle read latency through a 2-entry skid and delivers one
//   block of BLK samples per start on a valid/ready stream.
//   Ports:
//     clk, rst              clock, async active-low reset
//     start                 pulse: begin one block (ignored while busy)
//     abort                 cancel current block, back to IDLE (wins over start)
//     fill_thr[7:0]         occupancy needed before the first pop (clamped to BLK)
//     buf_push              copy of the buffer's push input
//     buf_pop               pop request to the buffer
//     buf_i, buf_q          buffer read data, valid the cycle after a pop
//     m_valid, m_ready      output stream handshake
//     m_i, m_q              output sample
//     m_idx[7:0], m_last    sample index in block, last-sample flag
//     busy, done, ovf       status: not idle, end-of-block pulse, sticky overflow
// ---------------------------------------------------------------------------
module buffer_drain_ctrl
  import buffer_drain_ctrl_pkg::*;
#(
  parameter int FP    = FP_DEF,
  parameter int DEPTH = BUF_DEPTH,
  parameter int BLK   = PBCH_BLK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        fill_thr,
  input  logic              buf_push,
  output logic              buf_pop,
  input  logic [FP/2-1:0]   buf_i,
  input  logic [FP/2-1:0]   buf_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP/2-1:0]   m_i,
  output logic [FP/2-1:0]   m_q,
  output logic [7:0]        m_idx,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int         W        = FP / 2;
  localparam logic [7:0] DEPTH_C  = 8'(DEPTH);
  localparam logic [7:0] BLK_C    = 8'(BLK);
  localparam logic [7:0] LAST_IDX = 8'(BLK - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] occ;
  logic [7:0] issued;
  logic [7:0] idx;
  logic       inflight;   // a pop happened last edge; its data is on buf_i now
  logic [1:0] skid_cnt;
  logic [2:0] pending;
  logic       room;
  logic       xfer;
  logic       thr_met;

  assign xfer    = m_valid & m_ready;
  assign thr_met = (occ >= clamp_thr(fill_thr, BLK_C));

  // Samples that will sit in the skid once everything already requested has
  // landed. A transfer this cycle frees one slot, which is what allows one
  // pop per clock while the stream is flowing.
  assign pending = {1'b0, skid_cnt} + {2'b00, inflight};
  assign room    = xfer ? (pending < 3'd3) : (pending < 3'd2);

  // Gated by the registered occupancy only: a push in the same cycle does not
  // make an empty buffer poppable.
  assign buf_pop = (state == ST_DRAIN) && (occ != 8'd0) && (issued < BLK_C) && room;

  assign m_valid = (skid_cnt != 2'd0);
  assign m_idx   = idx;
  assign m_last  = m_valid && (idx == LAST_IDX);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves
    // state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FILL;
      ST_FILL:  if (thr_met) state_nxt = ST_DRAIN;
      ST_DRAIN: if (issued == BLK_C) state_nxt = ST_FLUSH;
      ST_FLUSH: if (xfer && (idx == LAST_IDX)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Occupancy mirror: follows the buffer's own push/pop rules exactly.
  // abort does not touch it, since pops already issued did drain the buffer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= 8'd0;
      ovf <= 1'b0;
    end else begin
      case ({buf_push, buf_pop})
        2'b10: begin
          if (occ < DEPTH_C) occ <= occ + 8'd1;
          else               ovf <= 1'b1;
        end
        2'b01: if (occ != 8'd0) occ <= occ - 8'd1;
        2'b11: if (occ == 8'd0) occ <= 8'd1;  // buffer treats it as push only
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Issue / delivery counters and the read-latency flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued   <= 8'd0;
      idx      <= 8'd0;
      inflight <= 1'b0;
    end else if (abort) begin
      issued   <= 8'd0;
      idx      <= 8'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= buf_pop;
      if (state == ST_DONE) issued <= 8'd0;
      else if (buf_pop)     issued <= issued + 8'd1;
      if (xfer) idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    end
  end

  iq_skid2 #(.W(W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr    (abort),
    .wr     (inflight),
    .new_i  (buf_i),
    .new_q  (buf_q),
    .rd     (xfer),
    .head_i (m_i),
    .head_q (m_q),
    .cnt    (skid_cnt)
  );

endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buffer_drain_ctrl
//   Bench for buffer_drain_ctrl. Contains a behavioural model of the IQ
//   buffer (queue with a 1-cycle registered read) and a scoreboard of the
//   samples expected on the output stream. Rails are widened (FP=20) so the
//   sample numbers used below are carried exactly.
// ---------------------------------------------------------------------------
module tb_buffer_drain_ctrl;

  localparam int FP    = 20;
  localparam int W     = FP / 2;
  localparam int DEPTH = 144;
  localparam int BLK   = 144;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [7:0]   fill_thr;
  logic         buf_push;
  logic         buf_pop;
  logic [W-1:0] buf_i = '0;
  logic [W-1:0] buf_q = '0;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_i;
  logic [W-1:0] m_q;
  logic [7:0]   m_idx;
  logic         m_last;
  logic         busy;
  logic         done;
  logic         ovf;

  always #5 clk = ~clk;

  buffer_drain_ctrl #(.FP(FP), .DEPTH(DEPTH), .BLK(BLK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .fill_thr (fill_thr),
    .buf_push (buf_push),
    .buf_pop  (buf_pop),
    .buf_i    (buf_i),
    .buf_q    (buf_q),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_i      (m_i),
    .m_q      (m_q),
    .m_idx    (m_idx),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Buffer model + scoreboard state (owned by the negedge process)
  int push_val   = 0;
  int bq[$];
  int exp_q[$];
  int staged     = 0;
  bit staged_vld = 1'b0;
  int exp_idx    = 0;
  bit done_due   = 1'b0;
  int done_cnt   = 0;
  int xfer_cnt   = 0;
  int resync_req = 0;
  int resync_ack = 0;
  bit prev_stall = 1'b0;
  int prev_i     = 0;
  int prev_idx   = 0;

  // Everything is evaluated at the falling edge: inputs and DUT outputs are
  // stable there, and the decisions apply to the next rising edge. Read data
  // for a pop decided one negedge ago is presented now, i.e. after that pop's
  // rising edge and before the next one.
  always @(negedge clk) begin
    if (rst) begin
      if (staged_vld) begin
        buf_i = W'(staged);
        buf_q = W'(-staged);
      end
      staged_vld = 1'b0;

      if (resync_req != resync_ack) begin
        exp_q      = bq;
        exp_idx    = 0;
        done_due   = 1'b0;
        resync_ack = resync_req;
      end

      if (buf_pop) begin
        check("pop_nonempty", int'(bq.size() > 0), 1);
        if (bq.size() > 0) begin
          staged     = bq.pop_front();
          staged_vld = 1'b1;
        end
      end
      if (buf_push && bq.size() < DEPTH) begin
        bq.push_back(push_val);
        exp_q.push_back(push_val);
      end

      if (done_due) begin
        check("done_pulse", int'(done), 1);
        done_due = 1'b0;
      end else if (done) begin
        check("done_spurious", int'(done), 0);
      end
      if (done) done_cnt++;

      if (prev_stall && m_valid) begin
        check("hold_i", int'($signed(m_i)), prev_i);
        check("hold_idx", int'(m_idx), prev_idx);
      end
      prev_stall = m_valid && !m_ready;
      prev_i     = int'($signed(m_i));
      prev_idx   = int'(m_idx);

      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", int'(m_valid), 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("m_i", int'($signed(m_i)), e);
          check("m_q", int'($signed(m_q)), -e);
          check("m_idx", int'(m_idx), exp_idx);
          check("m_last", int'(m_last), int'(exp_idx == BLK - 1));
          if (exp_idx == BLK - 1) begin
            exp_idx  = 0;
            done_due = 1'b1;
          end else begin
            exp_idx++;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int n = 0; n < budget && done_cnt < target; n++) cycles(1);
    check(tag, done_cnt, target);
  endtask

  task automatic pulse_start(input int thr);
    fill_thr = 8'(thr);
    start    = 1'b1;
    cycles(1);
    start    = 1'b0;
  endtask

  initial begin
    int run;
    int base;
    int early;
    int done_tgt;

    rst = 1'b0; start = 1'b0; abort = 1'b0; fill_thr = 8'd0;
    buf_push = 1'b0; m_ready = 1'b0;
    done_tgt = 0;
    cycles(3);

    // Reset state
    check("rst_busy",    int'(busy), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_buf_pop", int'(buf_pop), 0);
    check("rst_done",    int'(done), 0);
    check("rst_ovf",     int'(ovf), 0);
    check("rst_m_idx",   int'(m_idx), 0);
    check("rst_m_last",  int'(m_last), 0);
    check("rst_m_i",     int'(m_i), 0);
    check("rst_occ",     int'(dut.occ), 0);
    rst = 1'b1;
    cycles(1);

    // T1: prefilled buffer, immediate drain, full throughput
    for (int n = 1; n <= BLK; n++) begin
      buf_push = 1'b1; push_val = n;
      cycles(1);
    end
    buf_push = 1'b0;
    check("t1_occ_full", int'(dut.occ), BLK);
    m_ready = 1'b1;
    pulse_start(0);
    for (int n = 0; n < 10 && !buf_pop; n++) cycles(1);
    run = 0;
    for (int n = 0; n < 300 && buf_pop; n++) begin
      run++;
      cycles(1);
    end
    check("t1_pop_run", run, BLK);
    done_tgt++;
    wait_done(done_tgt, 50, "t1_done");
    check("t1_xfers",   xfer_cnt, BLK);
    check("t1_occ_end", int'(dut.occ), 0);
    check("t1_exp_left", exp_q.size(), 0);
    check("t1_idle",    int'(busy), 0);

    // T2/T3: threshold 100, pushing after start, random backpressure
    base = xfer_cnt;
    pulse_start(100);
    early = 0;
    for (int n = 1; n <= 100; n++) begin
      buf_push = 1'b1; push_val = n;
      m_ready  = 1'($urandom_range(0, 1));
      cycles(1);
      early += int'(buf_pop);
    end
    buf_push = 1'b0;
    check("t2_no_early_pop", early, 0);
    cycles(1);
    check("t2_first_pop", int'(buf_pop), 1);
    check("t2_first_pop_occ", bq.size(), 100);
    for (int n = 101; n <= BLK; n++) begin
      buf_push = 1'b1; push_val = n;
      m_ready  = 1'($urandom_range(0, 1));
      cycles(1);
    end
    buf_push = 1'b0;
    done_tgt++;
    for (int n = 0; n < 2000 && done_cnt < done_tgt; n++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycles(1);
    end
    check("t3_done", done_cnt, done_tgt);
    check("t3_xfers", xfer_cnt - base, BLK);
    m_ready = 1'b1;
    cycles(1);

    // T4: empty buffer in DRAIN, push arrives, no pop that same cycle
    pulse_start(0);
    cycles(1);
    check("t4_busy", int'(busy), 1);
    check("t4_no_pop_empty", int'(buf_pop), 0);
    buf_push = 1'b1; push_val = 300;
    #1;
    check("t4_no_pop_on_push", int'(buf_pop), 0);
    cycles(1);
    check("t4_occ_one", int'(dut.occ), 1);
    check("t4_pop_after", int'(buf_pop), 1);

    // T5: stall at m_idx=60 with the skid full, then abort
    base = xfer_cnt;
    for (int n = 1; n <= 100; n++) begin
      buf_push = 1'b1; push_val = 300 + n;
      cycles(1);
      if (xfer_cnt - base >= 60) m_ready = 1'b0;
    end
    buf_push = 1'b0;
    cycles(4);
    check("t5_xfers", xfer_cnt - base, 60);
    check("t5_valid_stalled", int'(m_valid), 1);
    check("t5_idx_stalled", int'(m_idx), 60);
    check("t5_skid_full", int'(dut.skid_cnt), 2);
    check("t5_buf_left", bq.size(), 39);
    base = done_cnt;
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    resync_req++;
    check("t5_abort_idle", int'(busy), 0);
    check("t5_abort_valid", int'(m_valid), 0);
    check("t5_abort_idx", int'(m_idx), 0);
    check("t5_abort_occ", int'(dut.occ), 39);
    cycles(3);
    check("t5_no_done", done_cnt, base);
    m_ready = 1'b1;
    base = xfer_cnt;
    pulse_start(0);
    for (int n = 1; n <= 105; n++) begin
      buf_push = 1'b1; push_val = 400 + n;
      cycles(1);
    end
    buf_push = 1'b0;
    done_tgt++;
    wait_done(done_tgt, 100, "t5_done");
    check("t5_xfers_restart", xfer_cnt - base, BLK);
    check("t5_occ_end", int'(dut.occ), 0);

    // T6: overflow, then asynchronous reset mid-drain
    for (int n = 1; n <= DEPTH; n++) begin
      buf_push = 1'b1; push_val = n;
      cycles(1);
    end
    check("t6_ovf_before", int'(ovf), 0);
    push_val = DEPTH + 1;
    cycles(1);
    buf_push = 1'b0;
    check("t6_ovf_set", int'(ovf), 1);
    check("t6_occ_sat", int'(dut.occ), DEPTH);
    base = xfer_cnt;
    pulse_start(0);
    for (int n = 0; n < 100 && xfer_cnt - base < 20; n++) cycles(1);
    check("t6_xfers", xfer_cnt - base, 20);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_busy",    int'(busy), 0);
    check("t6_rst_m_valid", int'(m_valid), 0);
    check("t6_rst_buf_pop", int'(buf_pop), 0);
    check("t6_rst_ovf",     int'(ovf), 0);
    check("t6_rst_m_idx",   int'(m_idx), 0);
    check("t6_rst_m_i",     int'(m_i), 0);
    check("t6_rst_m_q",     int'(m_q), 0);
    check("t6_rst_done",    int'(done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
